stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
- Multi-cycle control FSM for the MIPS core; owns the 3-bit `stage` bus consumed by fetch, decode, ALU, memory and write-back blocks.
- Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB, skipping stages per instruction class.
- Waits on the data-memory ready handshake, generates PC update and register-file write enables, and halts on the END opcode.
- Keeps a retired-instruction count.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction and performance counters.
- MEM_TIMEOUT, 16, maximum cycles spent in MEM waiting for mem_ready before a fault is declared; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins execution from IDLE.
- opcode  in  6  decoded opcode from decode.
- branch  in  1  decode control output.
- memRead  in  1  decode control output.
- memWrite  in  1  decode control output.
- regWrite  in  1  decode control output.
- endProgram  in  1  decode control output.
- alu_zero  in  1  ALU zero flag.
- mem_ready  in  1  data memory access complete.
- stage  out  3  current stage encoding.
- pc_write  out  1  one-cycle PC update pulse.
- pc_src  out  1  1 = branch target, 0 = PC+4; valid with pc_write.
- rf_we  out  1  register-file write strobe.
- busy  out  1  not in IDLE or HALT.
- halted  out  1  in HALT.
- fault  out  1  sticky; illegal opcode or memory timeout.
- instr_count  out  CNT_WIDTH  retired instructions.
- cycle_count  out  CNT_WIDTH  busy cycles (feature-gated).
- stall_count  out  CNT_WIDTH  MEM wait cycles (feature-gated).

Behaviour:
- Stage encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=6, IDLE=7. Datapath blocks act only on 0..4.
- Reset (async, any time, including mid-instruction): state IDLE, stage=7. pc_write, pc_src, rf_we, fault and all counters = 0. busy=0, halted=0.
- IDLE: start=1 → FETCH next cycle; otherwise hold.
- FETCH → DECODE → EXECUTE: one cycle each, unconditional.
- Decode registers its outputs on the edge ending DECODE. EXECUTE therefore sees valid opcode/control inputs, and the FSM decides from them there.
- EXECUTE transitions, first match wins:
  - endProgram=1 → HALT. No pc_write; instruction not counted.
  - opcode 000000 (R-type) → WB.
  - opcode 100011 (LW) or 101011 (SW) → MEM.
  - opcode 000100 (BEQ) or 000101 (BNE) → FETCH, with pc_write=1. pc_src = alu_zero XOR opcode[0] (taken BEQ: zero=1; taken BNE: zero=0).
  - Anything else → FETCH with pc_write=1, pc_src=0, fault set. Treated as NOP and counted.
- MEM: hold while mem_ready=0; a wait counter increments each held cycle.
  - mem_ready=1: LW → WB; SW → FETCH with pc_write=1, pc_src=0.
  - Wait counter reaching MEM_TIMEOUT with mem_ready still 0 → HALT, fault=1.
  - mem_ready=1 in the same cycle as the timeout → ready wins.
- WB: rf_we=1 for exactly this cycle, gated by regWrite. pc_write=1, pc_src=0. → FETCH.
- pc_write, rf_we: combinational from state plus inputs, asserted only in the cycle named. pc_src=0 whenever pc_write=0.
- instr_count: +1 on every pc_write cycle; saturates at all-ones.
- HALT: absorbing. start ignored; exit only via rst_n. halted=1, busy=0.
- start while busy: ignored.
- Minimum latencies: branch 3 cycles, R-type 4, SW 4 (ready immediately), LW 5.

Optional Feature:
- Macro STAGE_SEQ_PERF_EN.
- Defined:
  - cycle_count increments every cycle busy=1.
  - stall_count increments every MEM cycle with mem_ready=0.
  - Both saturate and both clear on reset.
- Undefined: both ports tied to 0 and no counter flops are inferred. Port list unchanged.

Decomposition:
- Shared package mips_pkg holds:
  - the stage encoding localparams: STG_FETCH, STG_DECODE, STG_EXEC, STG_MEM, STG_WB, STG_HALT, STG_IDLE;
  - the opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_END.
- One sub-module, sat_counter (parameter WIDTH; ports clk, rst_n, inc, count). It is instantiated for instr_count and for the two gated performance counters.

Test Plan:
- Reset, start=1 with R-type: stage 7→0→1→2→4→0. rf_we=1 only in the WB cycle. instr_count=1.
- BEQ with alu_zero=1: pc_write=1, pc_src=1 in EXECUTE. BNE with alu_zero=1: pc_src=0. Each takes 3 cycles; instr_count +1 each.
- LW with mem_ready low for 3 cycles: MEM held 4 cycles, then WB. stall_count=3 with STAGE_SEQ_PERF_EN, 0 without.
- SW with mem_ready held 0 and MEM_TIMEOUT=4: HALT after 4 MEM cycles. fault=1, halted=1, stage=6. A later start pulse has no effect.
- endProgram=1 in EXECUTE: HALT. instr_count unchanged, pc_write never asserted.
- rst_n dropped asynchronously mid-MEM: stage=7 and all outputs 0 immediately, without waiting for a clock edge. Next start runs normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared stage encodings, opcode constants and FSM state type for the multi-cycle MIPS core.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mips_pkg;

  // Stage bus encodings seen by fetch/decode/ALU/memory/write-back.
  localparam logic [2:0] STG_FETCH  = 3'd0;
  localparam logic [2:0] STG_DECODE = 3'd1;
  localparam logic [2:0] STG_EXEC   = 3'd2;
  localparam logic [2:0] STG_MEM    = 3'd3;
  localparam logic [2:0] STG_WB     = 3'd4;
  localparam logic [2:0] STG_HALT   = 3'd6;
  localparam logic [2:0] STG_IDLE   = 3'd7;

  // Primary opcode field values.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_END   = 6'b111111;

  // State values equal the stage codes so the stage bus is the state register itself.
  typedef enum logic [2:0] {
    S_FETCH  = STG_FETCH,
    S_DECODE = STG_DECODE,
    S_EXEC   = STG_EXEC,
    S_MEM    = STG_MEM,
    S_WB     = STG_WB,
    S_HALT   = STG_HALT,
    S_IDLE   = STG_IDLE
  } state_t;

endpackage

// File: rtl/stage_sequencer_sat_counter.sv
// Saturating up-counter used for retired-instruction and performance counts.
// Latency: an inc is visible on count one cycle later.
// Backpressure: none; holds at all-ones once saturated.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle control FSM driving the stage bus, PC/register-file enables and retired count.
// Latency: branch 3 cycles, R-type 4, SW 4, LW 5 (plus memory wait cycles).
// Backpressure: MEM holds on mem_ready=0 up to MEM_TIMEOUT cycles; STAGE_SEQ_PERF_EN adds cycle/stall counters.
module stage_sequencer
  import mips_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [5:0]           opcode,
  input  logic                 branch,
  input  logic                 memRead,
  input  logic                 memWrite,
  input  logic                 regWrite,
  input  logic                 endProgram,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic [2:0]           stage,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 rf_we,
  output logic                 busy,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  // Last wait-count value at which a still-unready MEM cycle declares a timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       is_load;
  logic       fault_set;

  // Class is decided from opcode alone; these decode strobes are redundant here.
  logic unused_ctl;
  assign unused_ctl = ^{branch, memRead, memWrite};

  assign stage  = state;
  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = (state == S_HALT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle strobes; EXECUTE decides from the registered decode outputs.
  always_comb begin
    state_nxt = state;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    rf_we     = 1'b0;
    fault_set = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (endProgram) begin
          state_nxt = S_HALT;
        end else if (opcode == OP_RTYPE) begin
          state_nxt = S_WB;
        end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_FETCH;
          pc_write  = 1'b1;
          if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
            // opcode[0] distinguishes BNE, inverting the taken sense of alu_zero.
            pc_src = alu_zero ^ opcode[0];
          end else begin
            fault_set = 1'b1;
          end
        end
      end
      S_MEM: begin
        // Ready wins over a timeout landing in the same cycle.
        if (mem_ready) begin
          if (is_load) begin
            state_nxt = S_WB;
          end else begin
            state_nxt = S_FETCH;
            pc_write  = 1'b1;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_HALT;
          fault_set = 1'b1;
        end
      end
      S_WB: begin
        rf_we     = regWrite;
        pc_write  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Memory wait counter, load/store flag captured in EXECUTE, sticky fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      is_load  <= 1'b0;
      fault    <= 1'b0;
    end else begin
      fault <= fault | fault_set;
      if (state == S_EXEC) begin
        is_load <= (opcode == OP_LW);
      end
      if ((state == S_MEM) && (state_nxt == S_MEM)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_write),
    .count (instr_count)
  );

`ifdef STAGE_SEQ_PERF_EN
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (busy),
    .count (cycle_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state == S_MEM) && !mem_ready),
    .count (stall_count)
  );
`else
  assign cycle_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized self-checking bench for stage_sequencer against a per-instruction trace model.
// Latency: each instruction's expected stage/strobe trace is built up front, then checked cycle by cycle.
// Backpressure: mem_ready wait lengths randomized, including the timeout boundary.
module tb_stage_sequencer;

  localparam int CW = 4;
  localparam int TO = 4;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
`ifdef STAGE_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int K_R = 0, K_BEQ = 1, K_BNE = 2, K_LW = 3, K_SW = 4, K_ILL = 5, K_END = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [5:0]    opcode = '0;
  logic          branch = 1'b0;
  logic          memRead = 1'b0;
  logic          memWrite = 1'b0;
  logic          regWrite = 1'b0;
  logic          endProgram = 1'b0;
  logic          alu_zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic [2:0]    stage;
  logic          pc_write, pc_src, rf_we, busy, halted, fault;
  logic [CW-1:0] instr_count, cycle_count, stall_count;

  stage_sequencer #(.CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .opcode      (opcode),
    .branch      (branch),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .regWrite    (regWrite),
    .endProgram  (endProgram),
    .alu_zero    (alu_zero),
    .mem_ready   (mem_ready),
    .stage       (stage),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .rf_we       (rf_we),
    .busy        (busy),
    .halted      (halted),
    .fault       (fault),
    .instr_count (instr_count),
    .cycle_count (cycle_count),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Architectural model state.
  logic [CW-1:0] e_instr, e_cycle, e_stall;
  logic          e_fault;

  typedef struct packed {
    logic [2:0] stg;
    logic       pcw;
    logic       src;
    logic       we;
    logic       rdy;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  function automatic exp_t mk(input logic [2:0] s, input logic p, input logic c, input logic w, input logic r);
    exp_t e;
    e.stg = s; e.pcw = p; e.src = c; e.we = w; e.rdy = r;
    return e;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101};
  endfunction

  task automatic chk_counters(input string pfx);
    chk({pfx, "_instr_count"}, instr_count, e_instr);
    chk({pfx, "_fault"}, fault, e_fault);
    chk({pfx, "_cycle_count"}, cycle_count, PERF ? e_cycle : {CW{1'b0}});
    chk({pfx, "_stall_count"}, stall_count, PERF ? e_stall : {CW{1'b0}});
  endtask

  task automatic chk_reset(input string pfx);
    e_instr = '0; e_cycle = '0; e_stall = '0; e_fault = 1'b0;
    chk({pfx, "_stage"}, stage, 7);
    chk({pfx, "_pc_write"}, pc_write, 0);
    chk({pfx, "_pc_src"}, pc_src, 0);
    chk({pfx, "_rf_we"}, rf_we, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_halted"}, halted, 0);
    chk_counters(pfx);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 of the first FETCH cycle.
  task automatic do_start();
    start = 1'b1;
    #4;
    chk("idle_stage", stage, 7);
    chk("idle_busy", busy, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // HALT is absorbing: a start pulse must change nothing.
  task automatic halt_probe();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("halt_hold_stage", stage, 6);
    chk("halt_hold_halted", halted, 1);
    chk("halt_hold_busy", busy, 0);
    chk("halt_hold_pc_write", pc_write, 0);
    chk_counters("halt_hold");
  endtask

  // Runs one instruction starting in its FETCH cycle. res: 0 continue, 1 halted, 2 reset mid-flight.
  task automatic run_instr(input int kind, input int wait_n, input logic rw, input logic z,
                           input int abort_at, output int res);
    logic       halt_exp;
    logic       taken;
    logic       to_hit;
    logic [5:0] op;
    q.delete();
    halt_exp = 1'b0;
    res = 0;
    case (kind)
      K_R:   op = 6'b000000;
      K_BEQ: op = 6'b000100;
      K_BNE: op = 6'b000101;
      K_LW:  op = 6'b100011;
      K_SW:  op = 6'b101011;
      K_ILL: begin
        op = 6'($urandom_range(0, 63));
        while (legal(op)) op = 6'($urandom_range(0, 63));
      end
      default: op = 6'($urandom_range(0, 63));
    endcase
    opcode     = op;
    endProgram = (kind == K_END);
    regWrite   = rw;
    alu_zero   = z;
    branch     = (kind == K_BEQ) || (kind == K_BNE);
    memRead    = (kind == K_LW);
    memWrite   = (kind == K_SW);

    q.push_back(mk(3'd0, 0, 0, 0, 0));
    q.push_back(mk(3'd1, 0, 0, 0, 0));
    case (kind)
      K_END: begin
        q.push_back(mk(3'd2, 0, 0, 0, 0));
        halt_exp = 1'b1;
      end
      K_R: begin
        q.push_back(mk(3'd2, 0, 0, 0, 0));
        q.push_back(mk(3'd4, 1, 0, rw, 0));
      end
      K_BEQ, K_BNE: begin
        taken = (kind == K_BEQ) ? z : !z;
        q.push_back(mk(3'd2, 1, taken, 0, 0));
      end
      K_ILL: begin
        q.push_back(mk(3'd2, 1, 0, 0, 0));
        e_fault = 1'b1;
      end
      default: begin
        q.push_back(mk(3'd2, 0, 0, 0, 0));
        to_hit = 1'b0;
        for (int k = 0; k < wait_n; k++) begin
          q.push_back(mk(3'd3, 0, 0, 0, 0));
          if (k + 1 == TO) begin
            to_hit = 1'b1;
            break;
          end
        end
        if (to_hit) begin
          halt_exp = 1'b1;
          e_fault  = 1'b1;
        end else if (kind == K_LW) begin
          q.push_back(mk(3'd3, 0, 0, 0, 1));
          q.push_back(mk(3'd4, 1, 0, rw, 0));
        end else begin
          q.push_back(mk(3'd3, 1, 0, 0, 1));
        end
      end
    endcase

    for (int i = 0; i < q.size(); i++) begin
      mem_ready = q[i].rdy;
      #4;
      chk("stage", stage, q[i].stg);
      chk("pc_write", pc_write, q[i].pcw);
      chk("pc_src", pc_src, q[i].src);
      chk("rf_we", rf_we, q[i].we);
      chk("busy", busy, 1);
      if (q[i].pcw) e_instr = sat(e_instr);
      e_cycle = sat(e_cycle);
      if ((q[i].stg == 3'd3) && !q[i].rdy) e_stall = sat(e_stall);
      if (i == abort_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        res = 2;
        break;
      end
      @(posedge clk);
      #1;
    end

    mem_ready = 1'b0;
    if (res != 2) begin
      chk_counters("end");
      if (halt_exp) begin
        chk("halt_stage", stage, 6);
        chk("halt_halted", halted, 1);
        chk("halt_busy", busy, 0);
        chk("halt_pc_write", pc_write, 0);
        res = 1;
      end else begin
        chk("next_fetch", stage, 0);
      end
    end
  endtask

  task automatic resume(input int res);
    if (res == 1) begin
      halt_probe();
      do_reset();
      do_start();
    end else if (res == 2) begin
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_start();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int sel, kind, ab, wn;
    e_instr = '0; e_cycle = '0; e_stall = '0; e_fault = 1'b0;
    do_reset();
    do_start();

    // Directed walk through the main instruction classes and boundaries.
    run_instr(K_R,   0, 1'b1, 1'b0, -1, r); resume(r);
    run_instr(K_BEQ, 0, 1'b0, 1'b1, -1, r); resume(r);
    run_instr(K_BNE, 0, 1'b0, 1'b1, -1, r); resume(r);
    run_instr(K_LW,  3, 1'b1, 1'b0, -1, r); resume(r);
    run_instr(K_SW,  0, 1'b0, 1'b0, -1, r); resume(r);
    run_instr(K_SW,  6, 1'b0, 1'b0, -1, r); resume(r);
    run_instr(K_LW,  6, 1'b1, 1'b0,  4, r); resume(r);
    run_instr(K_R,   0, 1'b0, 1'b0, -1, r); resume(r);
    run_instr(K_ILL, 0, 1'b0, 1'b0, -1, r); resume(r);
    run_instr(K_END, 0, 1'b0, 1'b0, -1, r); resume(r);

    // Random instruction stream; halts and mid-flight resets restart the program.
    for (int n = 0; n < 160; n++) begin
      sel  = $urandom_range(0, 19);
      kind = (sel < 5)  ? K_R   :
             (sel < 7)  ? K_BEQ :
             (sel < 9)  ? K_BNE :
             (sel < 12) ? K_LW  :
             (sel < 15) ? K_SW  :
             (sel < 18) ? K_ILL :
             (sel == 18) ? K_END : K_LW;
      wn = $urandom_range(0, 5);
      ab = -1;
      if (((kind == K_LW) || (kind == K_SW)) && ($urandom_range(0, 7) == 0)) begin
        ab = 3 + $urandom_range(0, 1);
      end
      run_instr(kind, wn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab, r);
      resume(r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
